imem_arb: RTL
=============

# imem_arb

Single-port instruction-memory arbiter for the pipelined RV32I core. Shares one synchronous-read/synchronous-write imem array between the Fetch stage (read-only) and a program loader (burst writes at bring-up or by debug). Sits between the Fetch stage, the loader and the imem macro, and owns all imem enable, write and address lines.

## Interface
Parameters:
- ADDR_W, 6: imem word-address width (64 words).
- LEN_W, 7: burst-length width; maximum burst is 2^LEN_W−1 words.
- YIELD_N, 8: consecutive loader writes before one cycle is yielded to fetch (only with `IMEM_ARB_FAIRNESS_EN`).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- f_req  in  1  fetch read request.
- f_addr  in  32  fetch byte address; word index is f_addr[ADDR_W+1:2]; bits [1:0] are ignored.
- f_gnt  out  1  fetch request accepted this cycle (combinational).
- f_rvalid  out  1  fetch read data valid; registered, one cycle after f_gnt.
- f_rdata  out  32  fetch read data; equals mem_rdata while f_rvalid=1, 0 otherwise.
- l_start  in  1  loader burst start pulse; sampled only in IDLE.
- l_base  in  ADDR_W  burst start word index, latched on accepted l_start.
- l_len  in  LEN_W  burst word count, latched on accepted l_start.
- l_wvalid  in  1  loader write data valid.
- l_wdata  in  32  loader write data.
- l_wready  out  1  arbiter accepts l_wdata this cycle.
- l_busy  out  1  burst in progress (LOAD state).
- l_done  out  1  one-cycle pulse at burst completion.
- mem_en  out  1  imem access enable.
- mem_we  out  1  imem write enable.
- mem_addr  out  ADDR_W  imem word address.
- mem_wdata  out  32  imem write data.
- mem_rdata  in  32  imem read data, valid the cycle after a read access.

## Operation
- States: IDLE, LOAD, DONE.
- IDLE:
  - f_gnt = f_req.
  - A granted read drives mem_en=1, mem_we=0, mem_addr = fetch word index.
  - l_start=1 latches l_base and l_len, clears cnt and moves to LOAD. If f_req is asserted in the same cycle, the fetch is still granted in that cycle.
- LOAD:
  - l_busy=1, and l_wready=1 except during yield cycles.
  - A write occurs when l_wvalid && l_wready. It drives mem_en=1, mem_we=1, mem_addr = (base+cnt) mod 2^ADDR_W, mem_wdata = l_wdata, then increments cnt.
  - The write with cnt = len−1 moves the FSM to DONE.
  - A latched len of 0 moves to DONE on the first LOAD cycle with no writes; l_wready=0 in that cycle.
  - l_start is ignored while in LOAD.
- DONE: l_done=1 for one cycle, fetch is served as in IDLE, then the FSM returns to IDLE.
- Address arithmetic wraps modulo 2^ADDR_W; there is no error on wrap.
- Reset, including mid-burst: FSM goes to IDLE, cnt=0, and the partial burst is abandoned with no l_done. Writes already performed remain in imem.

## Timing
- Reset values: f_gnt, f_rvalid, f_rdata, l_wready, l_busy, l_done, mem_en, mem_we all 0; mem_addr and mem_wdata are 0.
- Fetch latency: request granted in cycle N, f_rvalid and f_rdata in cycle N+1. Back-to-back grants give one word per cycle.
- A grant in the cycle in which reset_n is sampled low produces no f_rvalid in the following cycle.
- Loader throughput: one word per cycle while l_wvalid is held. Burst of L words completes with l_done exactly one cycle after the last write.
- l_busy rises the cycle after an accepted l_start and falls in the DONE cycle.

## Configuration
- Macro: `IMEM_ARB_FAIRNESS_EN`.
- Defined:
  - After YIELD_N consecutive LOAD writes, if f_req=1, the next LOAD cycle has l_wready=0 and f_gnt=1 (fetch read issued). The yield counter then clears.
  - With f_req=0 there is no yield, and the counter holds at YIELD_N until a yield occurs or the burst ends.
  - Cycles with no write (l_wvalid=0) do not count toward YIELD_N.
- Undefined: f_gnt=0 throughout LOAD; fetch is fully blocked for the whole burst.

## Structure
- Package imem_arb_pkg holds:
  - state enum arb_state_e {IDLE, LOAD, DONE};
  - localparam defaults for ADDR_W, LEN_W and YIELD_N;
  - function word_idx() for the byte-to-word address conversion.
- Single module. The yield counter is inline, guarded by the macro. No sub-module.

## Test plan
- Reset, then f_req=1 with f_addr=0x4 against preloaded imem[1]=0x00100113 -> f_gnt=1 in that cycle; f_rvalid=1 and f_rdata=0x00100113 the next cycle. All outputs are 0 during reset.
- l_start with base=0, len=4, wdata 0x00000093, 0x00100113, 0x002081b3, 0x0001a103 back-to-back -> 4 writes to addresses 0..3, then l_done pulse one cycle later. Fetch reads of addresses 0x0 to 0xC then return those words.
- Burst with base=62, len=4 -> writes land at addresses 62, 63, 0, 1; l_len=0 -> l_done with no mem_we.
- f_req held during a 20-word burst -> without the macro, f_gnt=0 for the whole LOAD state. With `IMEM_ARB_FAIRNESS_EN` and YIELD_N=8, yields occur after writes 8 and 16, and l_done still occurs after word 20.
- reset_n low after 3 of 10 writes -> immediate IDLE, no l_done, l_busy=0, imem[base..base+2] hold the written data.
- l_start and f_req asserted in the same IDLE cycle -> fetch granted, l_busy=1 the next cycle; a second l_start during LOAD is ignored.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
// Provides the arbiter state encoding and the byte-to-word address helper.
package imem_arb_pkg;

    localparam int unsigned DEF_ADDR_W  = 6;
    localparam int unsigned DEF_LEN_W   = 7;
    localparam int unsigned DEF_YIELD_N = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } arb_state_e;

    // Word index of a byte address; callers truncate to their address width.
    function automatic logic [31:0] word_idx(input logic [31:0] byte_addr);
        return {2'b00, byte_addr[31:2]};
    endfunction

endpackage

// File: rtl/imem_arb.sv
// Single-port imem arbiter between the fetch stage (reads) and the program loader (bursts).
// Optional fetch yielding during bursts is enabled with `IMEM_ARB_FAIRNESS_EN.
module imem_arb
    import imem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned LEN_W   = DEF_LEN_W,
    parameter int unsigned YIELD_N = DEF_YIELD_N
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    input  logic              l_start,
    input  logic [ADDR_W-1:0] l_base,
    input  logic [LEN_W-1:0]  l_len,
    input  logic              l_wvalid,
    input  logic [31:0]       l_wdata,
    output logic              l_wready,
    output logic              l_busy,
    output logic              l_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    arb_state_e        state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              rvalid_q;

    logic              fetch_ok;
    logic              wr_ok;
    logic              wr_fire;
    logic              yield_now;
    logic              grant;

`ifdef IMEM_ARB_FAIRNESS_EN
    localparam int unsigned YW = $clog2(YIELD_N + 1);
    logic [YW-1:0] yield_q, yield_d;
`else
    logic unused_yield_n;
    assign unused_yield_n = ^YIELD_N;
`endif

    // Access decode shared by next-state and output logic.
    always_comb begin
        fetch_ok  = 1'b0;
        wr_ok     = 1'b0;
        yield_now = 1'b0;
        case (state_q)
            IDLE, DONE: fetch_ok = 1'b1;
            LOAD: begin
`ifdef IMEM_ARB_FAIRNESS_EN
                yield_now = (yield_q == YW'(YIELD_N)) && f_req;
`endif
                wr_ok = (len_q != '0) && !yield_now;
            end
            default: ;
        endcase
        grant   = f_req && (fetch_ok || yield_now);
        wr_fire = wr_ok && l_wvalid;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            base_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            base_q   <= base_d;
            rvalid_q <= f_gnt;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (l_start) begin
                    base_d  = l_base;
                    len_d   = l_len;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (len_q == '0) begin
                    state_d = DONE;
                end else if (wr_fire) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q + LEN_W'(1) == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef IMEM_ARB_FAIRNESS_EN
    // Saturates at YIELD_N while fetch is idle; clears on a yield or outside LOAD.
    always_comb begin
        yield_d = yield_q;
        if (state_q != LOAD || yield_now) begin
            yield_d = '0;
        end else if (wr_fire && yield_q != YW'(YIELD_N)) begin
            yield_d = yield_q + YW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            yield_q <= '0;
        end else begin
            yield_q <= yield_d;
        end
    end
`endif

    // Outputs are forced low while reset is asserted.
    always_comb begin
        f_gnt     = 1'b0;
        l_wready  = 1'b0;
        l_busy    = 1'b0;
        l_done    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset_n) begin
            f_gnt    = grant;
            l_wready = wr_ok;
            l_busy   = (state_q == LOAD);
            l_done   = (state_q == DONE);
            if (wr_fire) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = base_q + ADDR_W'(cnt_q);
                mem_wdata = l_wdata;
            end else if (grant) begin
                mem_en   = 1'b1;
                mem_addr = ADDR_W'(word_idx(f_addr));
            end
        end
    end

    assign f_rvalid = rvalid_q;
    assign f_rdata  = rvalid_q ? mem_rdata : 32'h0;

endmodule
